reg_file_scoreboard: RTL and testbench
======================================

// Module: reg_file_scoreboard
// PURPOSE
//  Parametrised MIPS register file: 1 write port, 2 read ports, optional R0-hardwired-zero,
//  optional write-to-read bypass, optional registered read outputs.
//  Adds a per-register pending-write scoreboard. The multicycle control unit uses it to
//  stall on RAW hazards when write-back is deferred. Sits in the datapath between the
//  decode stage and the ALU operand latches; it supersedes the fixed 32x32 register file.
// PARAMETERS
//  N         32  data width in bits
//  ADDR_W    5   register address width; depth = 2**ADDR_W
//  ZERO_REG  1   1: register 0 reads 0, ignores writes, is never pending
//  BYPASS    1   1: a read of the register being written this cycle returns Write_Data_i
//  REG_OUT   0   0: combinational read data; 1: read data registered, 1-cycle latency
// PORTS
//  clk                 in   1        rising-edge clock
//  reset               in   1        asynchronous reset, active-low
//  Reg_Write_i         in   1        write enable
//  Write_Register_i    in   ADDR_W   write address
//  Write_Data_i        in   N        write data
//  Read_Register_1_i   in   ADDR_W   read address, port 1
//  Read_Register_2_i   in   ADDR_W   read address, port 2
//  Read_Data_1_o       out  N        read data, port 1
//  Read_Data_2_o       out  N        read data, port 2
//  Issue_i             in   1        instruction issued that will later write Issue_Register_i
//  Issue_Register_i    in   ADDR_W   destination register of the issued instruction
//  Flush_i             in   1        synchronous clear of all pending bits (exception/branch squash)
//  Busy_1_o            out  1        pending[Read_Register_1_i]
//  Busy_2_o            out  1        pending[Read_Register_2_i]
//  Hazard_o            out  1        Busy_1_o | Busy_2_o
//  Pending_Count_o     out  ADDR_W+1 number of set pending bits
// BEHAVIOUR
//  - Reset (reset=0, async): all registers 0. Pending vector 0 and Pending_Count_o=0.
//    If REG_OUT=1, Read_Data_*_o=0. Reset mid-operation discards any in-flight write/issue.
//  - Write: at posedge, if Reg_Write_i: reg[Write_Register_i] <= Write_Data_i.
//    If ZERO_REG and address 0, the write is dropped.
//  - Read, REG_OUT=0: Read_Data_k_o = reg[addr_k] in the same cycle.
//    REG_OUT=1: the value is captured at posedge and valid the next cycle.
//    The registered path captures the bypassed value when BYPASS=1.
//  - Bypass: if BYPASS and Reg_Write_i and Write_Register_i==addr_k, the port returns
//    Write_Data_i, except when ZERO_REG=1 and addr_k==0.
//    If BYPASS=0, the port returns the old register contents.
//  - ZERO_REG=1: reading address 0 returns 0 regardless of write or bypass.
//  - Scoreboard, per posedge, in priority order:
//    1. Flush_i: all pending <= 0. An Issue_i in the same cycle is also discarded.
//    2. Reg_Write_i clears pending[Write_Register_i].
//    3. Issue_i sets pending[Issue_Register_i].
//    If issue and write target the same register in the same cycle, the set wins (new producer).
//    Issue to register 0 with ZERO_REG=1 is ignored.
//  - Busy_k_o/Hazard_o are combinational from the current pending state and read address.
//    They do not see same-cycle issue or write. A write clearing a pending bit is therefore
//    reported one cycle later, unless BYPASS forwards the data.
//  - Pending_Count_o is registered and updated in the same edge as the pending vector.
//    Maximum value is 2**ADDR_W (2**ADDR_W-1 with ZERO_REG). It never wraps.
//  - Clearing a register that is not pending is legal and a no-op.
//    Issuing a register that is already pending keeps it pending and the count unchanged.
// STRUCTURE
//  - Shared package mips_rf_pkg: RF_ADDR_W=5, RF_DATA_W=32, constant REG_ZERO=5'd0,
//    and the default parameter values.
//  - One sub-module, rf_scoreboard: pending vector, flush/clear/set logic, popcount register.
//  - Storage array, bypass muxes and optional output registers stay in the top module.
// TESTING
//  1. Reset, then write 0xDEADBEEF to r5. Read r5 on both ports the next cycle -> 0xDEADBEEF.
//     Read r0 -> 0.
//  2. Write 0x12345678 to r0 (ZERO_REG=1) -> r0 reads 0. Pending_Count_o stays 0 after Issue r0.
//  3. BYPASS=1: write 0xA5A5A5A5 to r7 while reading r7 -> same-cycle read 0xA5A5A5A5.
//     BYPASS=0 -> old value 0.
//  4. Issue r3 -> Busy_1_o=1 and Hazard_o=1 with Read_Register_1_i=3, count=1.
//     Write r3 -> next cycle Busy_1_o=0, count=0.
//  5. Same cycle: write r4 and issue r4, r4 already pending -> r4 stays pending, count unchanged.
//     Then Flush_i with Issue r9 -> count=0, r9 not pending.
//  6. REG_OUT=1: write r2=0x55 then read r2 -> data on the cycle after address.
//     Assert reset mid-stream -> outputs and count 0 immediately (async).

Source files
------------

// File: rtl/mips_rf_pkg.sv
// mips_rf_pkg: shared widths, the hardwired-zero register index and register file defaults
package mips_rf_pkg;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam logic [RF_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS = 1;
  localparam int DEF_REG_OUT = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits with flush/clear/set priority and a registered popcount
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  output logic              busy_1,
  output logic              busy_2,
  output logic [ADDR_W:0]   count
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] pending, pending_nxt;
  logic [ADDR_W:0] count_nxt;
  // set is applied after clear so a same-cycle new producer stays pending; flush overrides both
  always_comb begin
    pending_nxt = pending;
    if (clr) pending_nxt[clr_addr] = 1'b0;
    if (set && !(ZERO_REG != 0 && set_addr == ADDR_W'(REG_ZERO))) pending_nxt[set_addr] = 1'b1;
    if (flush) pending_nxt = '0;
  end
  always_comb begin
    count_nxt = '0;
    for (int i = 0; i < DEPTH; i++) count_nxt = count_nxt + (ADDR_W+1)'(pending_nxt[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      count <= '0;
    end else begin
      pending <= pending_nxt;
      count <= count_nxt;
    end
  end
  assign busy_1 = pending[addr_1];
  assign busy_2 = pending[addr_2];
endmodule

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: 1W2R register file with optional zero register, bypass, registered reads and RAW scoreboard
module reg_file_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int N = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS = DEF_BYPASS,
  parameter int REG_OUT = DEF_REG_OUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [N-1:0]      Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  output logic [N-1:0]      Read_Data_1_o,
  output logic [N-1:0]      Read_Data_2_o,
  input  logic              Issue_i,
  input  logic [ADDR_W-1:0] Issue_Register_i,
  input  logic              Flush_i,
  output logic              Busy_1_o,
  output logic              Busy_2_o,
  output logic              Hazard_o,
  output logic [ADDR_W:0]   Pending_Count_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(REG_ZERO);
  logic [N-1:0] regs [DEPTH];
  logic [N-1:0] rd_1, rd_2;
  logic wr_ok;
  assign wr_ok = Reg_Write_i && !(ZERO_REG != 0 && Write_Register_i == ZERO);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end
  // zero-register check comes first so a bypassed write to r0 never leaks through
  assign rd_1 = (ZERO_REG != 0 && Read_Register_1_i == ZERO) ? '0 :
                (BYPASS != 0 && Reg_Write_i && Write_Register_i == Read_Register_1_i) ? Write_Data_i :
                regs[Read_Register_1_i];
  assign rd_2 = (ZERO_REG != 0 && Read_Register_2_i == ZERO) ? '0 :
                (BYPASS != 0 && Reg_Write_i && Write_Register_i == Read_Register_2_i) ? Write_Data_i :
                regs[Read_Register_2_i];
  generate
    if (REG_OUT != 0) begin : g_reg_out
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          Read_Data_1_o <= '0;
          Read_Data_2_o <= '0;
        end else begin
          Read_Data_1_o <= rd_1;
          Read_Data_2_o <= rd_2;
        end
      end
    end else begin : g_comb_out
      assign Read_Data_1_o = rd_1;
      assign Read_Data_2_o = rd_2;
    end
  endgenerate
  rf_scoreboard #(.ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .flush    (Flush_i),
    .clr      (Reg_Write_i),
    .clr_addr (Write_Register_i),
    .set      (Issue_i),
    .set_addr (Issue_Register_i),
    .addr_1   (Read_Register_1_i),
    .addr_2   (Read_Register_2_i),
    .busy_1   (Busy_1_o),
    .busy_2   (Busy_2_o),
    .count    (Pending_Count_o)
  );
  assign Hazard_o = Busy_1_o | Busy_2_o;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// tb_reg_file_scoreboard: directed vectors against default, no-bypass and registered-output instances
module tb_reg_file_scoreboard;
  logic clk = 1'b0, reset = 1'b0;
  logic we = 1'b0, issue = 1'b0, flush = 1'b0;
  logic [4:0] wa = '0, ra_1 = '0, ra_2 = '0, ia = '0;
  logic [31:0] wd = '0;
  logic [31:0] d_1, d_2, nb_1, nb_2, ro_1, ro_2;
  logic b_1, b_2, hz, nb_b1, nb_b2, nb_hz, ro_b1, ro_b2, ro_hz;
  logic [5:0] cnt, nb_cnt, ro_cnt;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  reg_file_scoreboard u_dut (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra_1), .Read_Register_2_i(ra_2), .Read_Data_1_o(d_1), .Read_Data_2_o(d_2),
    .Issue_i(issue), .Issue_Register_i(ia), .Flush_i(flush),
    .Busy_1_o(b_1), .Busy_2_o(b_2), .Hazard_o(hz), .Pending_Count_o(cnt)
  );
  reg_file_scoreboard #(.BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra_1), .Read_Register_2_i(ra_2), .Read_Data_1_o(nb_1), .Read_Data_2_o(nb_2),
    .Issue_i(issue), .Issue_Register_i(ia), .Flush_i(flush),
    .Busy_1_o(nb_b1), .Busy_2_o(nb_b2), .Hazard_o(nb_hz), .Pending_Count_o(nb_cnt)
  );
  reg_file_scoreboard #(.REG_OUT(1)) u_ro (
    .clk(clk), .reset(reset), .Reg_Write_i(we), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra_1), .Read_Register_2_i(ra_2), .Read_Data_1_o(ro_1), .Read_Data_2_o(ro_2),
    .Issue_i(issue), .Issue_Register_i(ia), .Flush_i(flush),
    .Busy_1_o(ro_b1), .Busy_2_o(ro_b2), .Hazard_o(ro_hz), .Pending_Count_o(ro_cnt)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #12 reset = 1'b1;
    #1;
    check("rst_cnt", 64'(cnt), 0);
    check("rst_rd1", 64'(d_1), 0);
    check("rst_ro1", 64'(ro_1), 0);
    check("rst_haz", 64'(hz), 0);
    step();
    we = 1; wa = 5; wd = 32'hDEADBEEF; ra_1 = 5; ra_2 = 5;
    #1;
    check("byp_r5", 64'(d_1), 32'hDEADBEEF);
    check("nobyp_r5", 64'(nb_1), 0);
    step();
    we = 0;
    #1;
    check("r5_p1", 64'(d_1), 32'hDEADBEEF);
    check("r5_p2", 64'(d_2), 32'hDEADBEEF);
    check("nb_r5", 64'(nb_2), 32'hDEADBEEF);
    check("ro_byp_cap", 64'(ro_1), 32'hDEADBEEF);
    ra_1 = 0;
    #1;
    check("r0_rd", 64'(d_1), 0);
    we = 1; wa = 0; wd = 32'h12345678; issue = 1; ia = 0;
    #1;
    check("r0_byp", 64'(d_1), 0);
    step();
    we = 0; issue = 0;
    #1;
    check("r0_after", 64'(d_1), 0);
    check("r0_iss_cnt", 64'(cnt), 0);
    we = 1; wa = 7; wd = 32'hA5A5A5A5; ra_1 = 7;
    #1;
    check("byp_r7", 64'(d_1), 32'hA5A5A5A5);
    check("nobyp_r7", 64'(nb_1), 0);
    step();
    we = 0; issue = 1; ia = 3; ra_1 = 3; ra_2 = 0;
    #1;
    check("busy_same_cyc", 64'(b_1), 0);
    step();
    issue = 0;
    #1;
    check("busy_r3", 64'(b_1), 1);
    check("haz_r3", 64'(hz), 1);
    check("cnt_r3", 64'(cnt), 1);
    we = 1; wa = 3; wd = 32'h33;
    #1;
    check("busy_wr_cyc", 64'(b_1), 1);
    step();
    we = 0;
    #1;
    check("busy_r3_clr", 64'(b_1), 0);
    check("haz_clr", 64'(hz), 0);
    check("cnt_clr", 64'(cnt), 0);
    issue = 1; ia = 4; ra_2 = 4;
    step();
    issue = 0;
    #1;
    check("busy2_r4", 64'(b_2), 1);
    check("cnt_r4", 64'(cnt), 1);
    we = 1; wa = 4; wd = 32'h44; issue = 1; ia = 4;
    step();
    we = 0; issue = 0;
    #1;
    check("r4_set_wins", 64'(b_2), 1);
    check("cnt_r4_same", 64'(cnt), 1);
    issue = 1; ia = 31;
    step();
    #1;
    check("cnt_two", 64'(cnt), 2);
    check("cnt_nb_two", 64'(nb_cnt), 2);
    issue = 1; ia = 31;
    step();
    issue = 0;
    #1;
    check("reissue_cnt", 64'(cnt), 2);
    flush = 1; issue = 1; ia = 9;
    step();
    flush = 0; issue = 0; ra_1 = 9;
    #1;
    check("flush_cnt", 64'(cnt), 0);
    check("flush_r9", 64'(b_1), 0);
    check("flush_r4", 64'(b_2), 0);
    we = 1; wa = 2; wd = 32'h55;
    step();
    we = 0; ra_1 = 2;
    #1;
    check("ro_lat0", 64'(ro_1), 0);
    check("comb_r2", 64'(d_1), 32'h55);
    step();
    check("ro_lat1", 64'(ro_1), 32'h55);
    issue = 1; ia = 2;
    step();
    issue = 0;
    #1;
    check("ro_cnt", 64'(ro_cnt), 1);
    reset = 1'b0;
    #1;
    check("arst_ro1", 64'(ro_1), 0);
    check("arst_cnt", 64'(ro_cnt), 0);
    check("arst_regs", 64'(d_1), 0);
    check("arst_busy", 64'(ro_b1), 0);
    #2 reset = 1'b1;
    step();
    check("post_rst_r5", 64'(nb_1), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
